mat_nbr_fetch: RTL and testbench

// - Read-side sequencer for the FAST9 frame buffer: takes a (row, col) reference point and fetches its 8 neighbours plus centre.
// - Issues 9 single-cycle reads, collects the returned pixels, and presents them as one packed bundle with a valid/ready handshake.
// - Sits between the frame buffer read port and the corner-score datapath. Border points are flagged and are never fetched.

---
 rtl/mat_nbr_fetch_pkg.sv | 48 ++++
 rtl/mat_nbr_fetch_fb_nbr_addr.sv | 13 +
 rtl/mat_nbr_fetch.sv | 107 ++++++++++
 tb/tb_mat_nbr_fetch.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/mat_nbr_fetch_pkg.sv
// Shared FAST9 fetch definitions: frame geometry, widths, FSM encodings and the
// neighbour offset table used by the read sequencer.
package mat_nbr_fetch_pkg;

  localparam int unsigned COLUMNS = 180;
  localparam int unsigned ROWS    = 120;
  localparam int unsigned ADDR_W  = 15;
  localparam int unsigned PIX_W   = 8;
  localparam int unsigned NBR_CNT = 9;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] HOLD  = 2'd3;

  typedef struct packed {
    logic       valid;
    logic [3:0] idx;
  } rdTag_t;

  // Adjacency order 0..7 clockwise from north, index 8 is the centre.
  function automatic logic [ADDR_W-1:0] nbrOfs(input logic [3:0] idx);
    case (idx)
      4'd0:    nbrOfs = ADDR_W'(-180);
      4'd1:    nbrOfs = ADDR_W'(-179);
      4'd2:    nbrOfs = ADDR_W'(1);
      4'd3:    nbrOfs = ADDR_W'(181);
      4'd4:    nbrOfs = ADDR_W'(180);
      4'd5:    nbrOfs = ADDR_W'(179);
      4'd6:    nbrOfs = ADDR_W'(-1);
      4'd7:    nbrOfs = ADDR_W'(-181);
      default: nbrOfs = '0;
    endcase
  endfunction

  // row*180 + col as shift-add: 180 = 128 + 32 + 16 + 4.
  function automatic logic [ADDR_W-1:0] refAddrOf(input logic [6:0] row, input logic [7:0] col);
    logic [ADDR_W-1:0] r;
    r = {8'b0, row};
    refAddrOf = (r << 7) + (r << 5) + (r << 4) + (r << 2) + {7'b0, col};
  endfunction

  function automatic logic isBorder(input logic [6:0] row, input logic [7:0] col);
    isBorder = (row == 7'd0) || (row >= 7'(ROWS - 1)) ||
               (col == 8'd0) || (col >= 8'(COLUMNS - 1));
  endfunction

endpackage

// File: rtl/mat_nbr_fetch_fb_nbr_addr.sv
// Combinational neighbour address generator: reference address plus the
// table offset for the current fetch index, wrapping in 15-bit arithmetic.
module mat_nbr_fetch_fb_nbr_addr
  import mat_nbr_fetch_pkg::*;
(
  input  logic [ADDR_W-1:0] refAddr,
  input  logic [3:0]        idx,
  output logic [ADDR_W-1:0] fbAddr
);

  assign fbAddr = refAddr + nbrOfs(idx);

endmodule

// File: rtl/mat_nbr_fetch.sv
// FAST9 neighbour fetch sequencer: issues nine frame buffer reads around a
// reference point and presents the returned pixels as one handshaked bundle.
module mat_nbr_fetch
  import mat_nbr_fetch_pkg::*;
#(
  parameter int unsigned FB_LAT = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 reqValid,
  output logic                 reqReady,
  input  logic [6:0]           refRow,
  input  logic [7:0]           refCol,
  output logic                 fbRd,
  output logic [ADDR_W-1:0]    fbAddr,
  input  logic [PIX_W-1:0]     fbData,
  output logic                 outValid,
  input  logic                 outReady,
  output logic [8*PIX_W-1:0]   outNbr,
  output logic [PIX_W-1:0]     outCenter,
  output logic                 outBorder
);

  logic [1:0]        stateQ, stateD;
  logic [3:0]        idxQ;
  logic [ADDR_W-1:0] refAddrQ;
  logic [ADDR_W-1:0] rdAddr;
  logic              borderQ;
  rdTag_t            tagQ [FB_LAT];
  rdTag_t            tagOut;
  logic [PIX_W-1:0]  pixQ [NBR_CNT];
  logic              accept;
  logic              reqBorder;
  logic              lastBack;
  logic              handshake;

  assign reqReady  = (stateQ == IDLE);
  assign accept    = reqValid && reqReady;
  assign reqBorder = isBorder(refRow, refCol);
  assign tagOut    = tagQ[FB_LAT-1];
  assign lastBack  = tagOut.valid && (tagOut.idx == 4'd8);
  assign outValid  = (stateQ == HOLD);
  assign handshake = outValid && outReady;

  always_comb begin
    stateD = stateQ;
    case (stateQ)
      IDLE:    if (accept) stateD = reqBorder ? HOLD : ISSUE;
      ISSUE:   if (idxQ == 4'd8) stateD = DRAIN;
      DRAIN:   if (lastBack) stateD = HOLD;
      HOLD:    if (outReady) stateD = IDLE;
      default: stateD = IDLE;
    endcase
  end

  mat_nbr_fetch_fb_nbr_addr uAddr (
    .refAddr (refAddrQ),
    .idx     (idxQ),
    .fbAddr  (rdAddr)
  );

  assign fbRd   = (stateQ == ISSUE);
  assign fbAddr = fbRd ? rdAddr : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateQ   <= IDLE;
      idxQ     <= '0;
      refAddrQ <= '0;
      borderQ  <= 1'b0;
      for (int i = 0; i < FB_LAT; i++) tagQ[i] <= '0;
      for (int k = 0; k < NBR_CNT; k++) pixQ[k] <= '0;
    end else begin
      stateQ <= stateD;
      if (accept) begin
        idxQ     <= '0;
        refAddrQ <= refAddrOf(refRow, refCol);
        borderQ  <= reqBorder;
      end else if (stateQ == ISSUE) begin
        idxQ <= idxQ + 4'd1;
      end
      if (handshake) borderQ <= 1'b0;

      // Tag travels alongside the read so the return lands in the right slot.
      tagQ[0] <= '{valid: (stateQ == ISSUE), idx: idxQ};
      for (int i = 1; i < FB_LAT; i++) tagQ[i] <= tagQ[i-1];

      // Slots are wiped on every accept so a bundle never carries stale pixels.
      for (int k = 0; k < NBR_CNT; k++) begin
        if (accept) begin
          pixQ[k] <= '0;
        end else if (tagOut.valid && (tagOut.idx == 4'(k))) begin
          pixQ[k] <= fbData;
        end
      end
    end
  end

  always_comb begin
    outNbr = '0;
    for (int k = 0; k < 8; k++) outNbr[k*PIX_W +: PIX_W] = pixQ[k];
  end

  assign outCenter = pixQ[8];
  assign outBorder = borderQ;

endmodule

// File: tb/tb_mat_nbr_fetch.sv
// Directed bench for mat_nbr_fetch: two instances (read latency 1 and 3) fed by
// a frame buffer model whose pixel at address a is a[7:0].
module tb_mat_nbr_fetch;
  import mat_nbr_fetch_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic              reqValid = 1'b0, outReady = 1'b0;
  logic [6:0]        refRow = '0;
  logic [7:0]        refCol = '0;
  logic              reqReady, fbRd, outValid, outBorder;
  logic [ADDR_W-1:0] fbAddr;
  logic [PIX_W-1:0]  fbData, outCenter;
  logic [63:0]       outNbr;

  logic              reqValid3 = 1'b0, outReady3 = 1'b0;
  logic [6:0]        refRow3 = '0;
  logic [7:0]        refCol3 = '0;
  logic              reqReady3, fbRd3, outValid3, outBorder3;
  logic [ADDR_W-1:0] fbAddr3;
  logic [PIX_W-1:0]  fbData3, outCenter3;
  logic [63:0]       outNbr3;
  logic [7:0]        mem3Q [3];

  int nChecks = 0;
  int nErrors = 0;
  int ofsTab [9] = '{-180, -179, 1, 181, 180, 179, -1, -181, 0};
  int bRow [5] = '{0, 119, 5, 5, 130};
  int bCol [5] = '{5, 5, 0, 179, 200};

  always #5 clk = ~clk;

  mat_nbr_fetch #(.FB_LAT(1)) dut1 (
    .clk(clk), .reset(reset), .reqValid(reqValid), .reqReady(reqReady),
    .refRow(refRow), .refCol(refCol), .fbRd(fbRd), .fbAddr(fbAddr), .fbData(fbData),
    .outValid(outValid), .outReady(outReady), .outNbr(outNbr), .outCenter(outCenter),
    .outBorder(outBorder)
  );

  mat_nbr_fetch #(.FB_LAT(3)) dut3 (
    .clk(clk), .reset(reset), .reqValid(reqValid3), .reqReady(reqReady3),
    .refRow(refRow3), .refCol(refCol3), .fbRd(fbRd3), .fbAddr(fbAddr3), .fbData(fbData3),
    .outValid(outValid3), .outReady(outReady3), .outNbr(outNbr3), .outCenter(outCenter3),
    .outBorder(outBorder3)
  );

  // Frame buffer models: data appears 1 and 3 cycles after the read strobe.
  always @(posedge clk) begin
    fbData   <= fbAddr[7:0];
    mem3Q[0] <= fbAddr3[7:0];
    mem3Q[1] <= mem3Q[0];
    mem3Q[2] <= mem3Q[1];
  end
  assign fbData3 = mem3Q[2];

  function automatic logic [63:0] expNbr(input int refA);
    logic [63:0] r;
    int a;
    r = '0;
    for (int k = 0; k < 8; k++) begin
      a = refA + ofsTab[k];
      r[k*8 +: 8] = a[7:0];
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChecks++;
    assert (obs === exp)
    else begin
      nErrors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic req1(input int row, input int col);
    @(negedge clk);
    reqValid = 1'b1;
    refRow   = row[6:0];
    refCol   = col[7:0];
    cyc();
    reqValid = 1'b0;
  endtask

  task automatic hs1();
    outReady = 1'b1;
    cyc();
    outReady = 1'b0;
    check("hs_reqReady", 64'(reqReady), 64'd1);
    check("hs_outValid", 64'(outValid), 64'd0);
  endtask

  task automatic checkReset(input string tag);
    check({tag, "_reqReady"}, 64'(reqReady), 64'd1);
    check({tag, "_fbRd"}, 64'(fbRd), 64'd0);
    check({tag, "_fbAddr"}, 64'(fbAddr), 64'd0);
    check({tag, "_outValid"}, 64'(outValid), 64'd0);
    check({tag, "_outNbr"}, outNbr, 64'd0);
    check({tag, "_outCenter"}, 64'(outCenter), 64'd0);
    check({tag, "_outBorder"}, 64'(outBorder), 64'd0);
  endtask

  initial begin
    #12;
    checkReset("rst");
    check("rst_reqReady3", 64'(reqReady3), 64'd1);
    @(negedge clk);
    reset = 1'b0;

    // Row 1, col 1: address walk and 10-edge latency.
    req1(1, 1);
    for (int k = 0; k < 9; k++) begin
      check("s1_fbRd", 64'(fbRd), 64'd1);
      check("s1_fbAddr", 64'(fbAddr), 64'(181 + ofsTab[k]));
      if (k == 0) check("s1_reqReadyBusy", 64'(reqReady), 64'd0);
      cyc();
    end
    check("s1_validEarly", 64'(outValid), 64'd0);
    check("s1_drainNoRd", 64'(fbRd), 64'd0);
    cyc();
    check("s1_valid", 64'(outValid), 64'd1);
    check("s1_center", 64'(outCenter), 64'hB5);
    check("s1_nbr", outNbr, expNbr(181));
    check("s1_border", 64'(outBorder), 64'd0);
    hs1();

    // Point (60, 90), reference address 10890.
    req1(60, 90);
    repeat (10) cyc();
    check("s2_valid", 64'(outValid), 64'd1);
    check("s2_slot0", 64'(outNbr[7:0]), 64'hD6);
    check("s2_center", 64'(outCenter), 64'h8A);
    check("s2_border", 64'(outBorder), 64'd0);
    check("s2_nbr", outNbr, expNbr(10890));

    // Consumer stalls for 20 cycles while new requests are offered.
    for (int i = 0; i < 20; i++) begin
      reqValid = i[0];
      refRow   = 7'd1;
      refCol   = 8'd1;
      cyc();
      check("hold_valid", 64'(outValid), 64'd1);
      check("hold_reqReady", 64'(reqReady), 64'd0);
      check("hold_nbr", outNbr, expNbr(10890));
      check("hold_center", 64'(outCenter), 64'h8A);
    end
    reqValid = 1'b0;
    hs1();

    // Border and out-of-range points: no reads, zeroed data.
    for (int p = 0; p < 5; p++) begin
      check("bd_noRdBefore", 64'(fbRd), 64'd0);
      req1(bRow[p], bCol[p]);
      check("bd_valid", 64'(outValid), 64'd1);
      check("bd_border", 64'(outBorder), 64'd1);
      check("bd_nbr", outNbr, 64'd0);
      check("bd_center", 64'(outCenter), 64'd0);
      check("bd_noRd", 64'(fbRd), 64'd0);
      cyc();
      check("bd_noRdLater", 64'(fbRd), 64'd0);
      check("bd_validHeld", 64'(outValid), 64'd1);
      hs1();
    end

    // Reset in the middle of the fetch at index 4.
    req1(1, 1);
    repeat (4) cyc();
    check("mr_fbRd", 64'(fbRd), 64'd1);
    check("mr_fbAddr", 64'(fbAddr), 64'd361);
    #1 reset = 1'b1;
    #1 checkReset("mr");
    cyc();
    reset = 1'b0;
    repeat (3) begin
      cyc();
      check("mr_idleRd", 64'(fbRd), 64'd0);
      check("mr_idleValid", 64'(outValid), 64'd0);
    end
    req1(2, 2);
    repeat (10) cyc();
    check("mr_valid", 64'(outValid), 64'd1);
    check("mr_nbr", outNbr, expNbr(362));
    check("mr_center", 64'(outCenter), 64'h6A);
    hs1();

    // Latency-3 build, row 1 col 1: valid on the 12th edge.
    @(negedge clk);
    reqValid3 = 1'b1;
    refRow3   = 7'd1;
    refCol3   = 8'd1;
    cyc();
    reqValid3 = 1'b0;
    repeat (11) cyc();
    check("l3_validEarly", 64'(outValid3), 64'd0);
    cyc();
    check("l3_valid", 64'(outValid3), 64'd1);
    check("l3_center", 64'(outCenter3), 64'hB5);
    check("l3_nbr", outNbr3, expNbr(181));
    check("l3_border", 64'(outBorder3), 64'd0);
    check("l3_fbAddrIdle", 64'(fbAddr3), 64'd0);
    outReady3 = 1'b1;
    cyc();
    outReady3 = 1'b0;
    check("l3_reqReady", 64'(reqReady3), 64'd1);
    check("l3_fbRd", 64'(fbRd3), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
